// File: rtl/crc32_stream_engine.sv
// Streaming CRC-32 engine: accumulates a CRC over framed beats of DATA_W bits,
// then presents the finalised CRC plus a residue (FCS good) flag per frame.
module crc32_stream_engine #(
    parameter int          DATA_W      = 32,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter logic [31:0] RESIDUE     = 32'hC704DD7B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_sop,
    input  logic                  s_eop,
    input  logic [DATA_W/8-1:0]   s_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_crc,
    output logic                  m_crc_ok,
    output logic                  sop_err
);

    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINAL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_crc_q, m_crc_d;
    logic        m_crc_ok_q, m_crc_ok_d;
    logic        sop_err_q, sop_err_d;

    logic [31:0] keep_ext;
    logic [31:0] nbytes;
    logic [31:0] crc_seed;
    logic [31:0] crc_chain [NB+1];
    logic        accept;

    // One byte through the serial LFSR: shift left, feedback = reg[31] ^ data bit.
    function automatic logic [31:0] byte_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[31] ^ (REFLECT_IN ? b[k] : b[7-k]);
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) begin
            r[k] = v[31-k];
        end
        return r;
    endfunction

    // Input stalls only while an unconsumed result is pending.
    assign s_ready  = !(m_valid_q && !m_ready);
    assign accept   = s_valid && s_ready;

    // Bytes to process this beat: full beat unless eop, where keep is clamped to NB.
    assign keep_ext = 32'(s_keep);
    assign nbytes   = !s_eop ? 32'(NB) : ((keep_ext > 32'(NB)) ? 32'(NB) : keep_ext);

    // A start-of-frame beat always restarts from INIT, whatever state we are in.
    assign crc_seed     = s_sop ? INIT : crc_q;
    assign crc_chain[0] = crc_seed;

    // Combinational unroll: byte 0 sits in the top byte lane and is processed first.
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign crc_chain[gi+1] = (32'(gi) < nbytes)
                               ? byte_step(crc_chain[gi], s_data[DATA_W-1-8*gi -: 8])
                               : crc_chain[gi];
    end

    // Next-state logic: result finalisation, beat acceptance and framing errors.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        m_valid_d  = m_valid_q;
        m_crc_d    = m_crc_q;
        m_crc_ok_d = m_crc_ok_q;
        sop_err_d  = sop_err_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // FINAL waits until the output slot is free (same condition as s_ready),
        // so a new result can load on the edge the old one is consumed.
        if (state_q == ST_FINAL && s_ready) begin
            m_valid_d  = 1'b1;
            m_crc_d    = (REFLECT_OUT ? bitrev32(crc_q) : crc_q) ^ XOR_OUT;
            m_crc_ok_d = (crc_q == RESIDUE);
            crc_d      = INIT;
            state_d    = ST_IDLE;
        end

        if (accept) begin
            if (state_q == ST_ACTIVE) begin
                // sop inside a frame is an error but still restarts the frame.
                if (s_sop) begin
                    sop_err_d = 1'b1;
                end
                crc_d   = crc_chain[NB];
                state_d = s_eop ? ST_FINAL : ST_ACTIVE;
            end else if (s_sop) begin
                crc_d   = crc_chain[NB];
                state_d = s_eop ? ST_FINAL : ST_ACTIVE;
            end else begin
                // Stray beat outside a frame: dropped.
                sop_err_d = 1'b1;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            crc_q      <= INIT;
            m_valid_q  <= 1'b0;
            m_crc_q    <= 32'h0;
            m_crc_ok_q <= 1'b0;
            sop_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            m_valid_q  <= m_valid_d;
            m_crc_q    <= m_crc_d;
            m_crc_ok_q <= m_crc_ok_d;
            sop_err_q  <= sop_err_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_crc    = m_crc_q;
    assign m_crc_ok = m_crc_ok_q;
    assign sop_err  = sop_err_q;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Directed bench for crc32_stream_engine: 8-bit and 32-bit reflected CRC-32,
// plus a 32-bit BZIP2 instance sharing the 32-bit stimulus.
module tb_crc32_stream_engine;

    logic clk;
    logic rst;

    // 32-bit lanes (shared by the reflected and BZIP2 instances)
    logic        s_valid, s_sop, s_eop, m_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_ready, m_valid, m_crc_ok, sop_err;
    logic [31:0] m_crc;
    logic        bz_s_ready, bz_m_valid, bz_m_crc_ok, bz_sop_err;
    logic [31:0] bz_m_crc;

    // 8-bit lanes
    logic        s8_valid, s8_sop, s8_eop, m8_ready;
    logic [7:0]  s8_data;
    logic [0:0]  s8_keep;
    logic        s8_ready, m8_valid, m8_crc_ok, sop8_err;
    logic [31:0] m8_crc;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc32_stream_engine #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop), .s_keep(s_keep), .m_valid(m_valid), .m_ready(m_ready),
        .m_crc(m_crc), .m_crc_ok(m_crc_ok), .sop_err(sop_err)
    );

    crc32_stream_engine #(.DATA_W(32), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) dut_bz (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(bz_s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop), .s_keep(s_keep), .m_valid(bz_m_valid), .m_ready(m_ready),
        .m_crc(bz_m_crc), .m_crc_ok(bz_m_crc_ok), .sop_err(bz_sop_err)
    );

    crc32_stream_engine #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s8_data),
        .s_sop(s8_sop), .s_eop(s8_eop), .s_keep(s8_keep), .m_valid(m8_valid), .m_ready(m8_ready),
        .m_crc(m8_crc), .m_crc_ok(m8_crc_ok), .sop_err(sop8_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one 32-bit beat and hold it until the handshake edge.
    task automatic beat32(input logic [31:0] d, input logic sop, input logic eop, input logic [3:0] keep);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_keep = keep;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat32_ready_timeout", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic beat8(input logic [7:0] d, input logic sop, input logic eop, input logic keep);
        int n;
        @(negedge clk);
        s8_valid = 1'b1; s8_data = d; s8_sop = sop; s8_eop = eop; s8_keep = keep;
        n = 0;
        while (!s8_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat8_ready_timeout", {31'b0, s8_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Called right after the eop handshake edge: result appears after one more edge.
    task automatic expect32(input string tag, input logic [31:0] exp_crc, input logic exp_ok);
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        chk({tag, "_early"}, {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
        chk({tag, "_crc"}, m_crc, exp_crc);
        chk({tag, "_ok"}, {31'b0, m_crc_ok}, {31'b0, exp_ok});
    endtask

    task automatic expect8(input string tag, input logic [31:0] exp_crc, input logic exp_ok);
        @(negedge clk);
        s8_valid = 1'b0; s8_sop = 1'b0; s8_eop = 1'b0;
        chk({tag, "_early"}, {31'b0, m8_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, m8_valid}, 32'd1);
        chk({tag, "_crc"}, m8_crc, exp_crc);
        chk({tag, "_ok"}, {31'b0, m8_crc_ok}, {31'b0, exp_ok});
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = 32'h0; s_keep = 4'h0; m_ready = 1'b1;
        s8_valid = 1'b0; s8_sop = 1'b0; s8_eop = 1'b0; s8_data = 8'h0; s8_keep = 1'b0; m8_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_crc", m_crc, 32'h0);
        chk("rst_m_crc_ok", {31'b0, m_crc_ok}, 32'd0);
        chk("rst_sop_err", {31'b0, sop_err}, 32'd0);
        chk("rst_m8_valid", {31'b0, m8_valid}, 32'd0);
        rst = 1'b0;

        // 8-bit lanes, "123456789", keep=1 on last byte
        for (int i = 0; i < 9; i++) beat8(msg[i], i == 0, i == 8, 1'b1);
        expect8("w8_check", 32'hCBF43926, 1'b0);

        // 8-bit lanes, same data plus an empty eop beat
        for (int i = 0; i < 9; i++) beat8(msg[i], i == 0, 1'b0, 1'b0);
        beat8(8'h00, 1'b0, 1'b1, 1'b0);
        expect8("w8_keep0", 32'hCBF43926, 1'b0);

        // 32-bit lanes, "1234" "5678" "9" keep=1; BZIP2 instance sees the same frame
        beat32(32'h31323334, 1'b1, 1'b0, 4'd0);
        beat32(32'h35363738, 1'b0, 1'b0, 4'd0);
        beat32(32'h39000000, 1'b0, 1'b1, 4'd1);
        expect32("w32_check", 32'hCBF43926, 1'b0);
        chk("bzip2_crc", bz_m_crc, 32'hFC891918);
        chk("bzip2_valid", {31'b0, bz_m_valid}, 32'd1);

        // Frame with appended FCS 26 39 F4 CB: residue matches
        beat32(32'h31323334, 1'b1, 1'b0, 4'd0);
        beat32(32'h35363738, 1'b0, 1'b0, 4'd0);
        beat32(32'h392639F4, 1'b0, 1'b0, 4'd0);
        beat32(32'hCB000000, 1'b0, 1'b1, 4'd1);
        expect32("fcs_good", 32'h2144DF1C, 1'b1);

        // One data bit flipped ('1' -> '0'): residue no longer matches
        beat32(32'h30323334, 1'b1, 1'b0, 4'd0);
        beat32(32'h35363738, 1'b0, 1'b0, 4'd0);
        beat32(32'h392639F4, 1'b0, 1'b0, 4'd0);
        beat32(32'hCB000000, 1'b0, 1'b1, 4'd1);
        @(negedge clk);
        s_valid = 1'b0; s_eop = 1'b0; s_sop = 1'b0;
        @(negedge clk);
        chk("fcs_bad_valid", {31'b0, m_valid}, 32'd1);
        chk("fcs_bad_ok", {31'b0, m_crc_ok}, 32'd0);

        // keep=7 clamps to 4: empty payload + zero FCS in one beat
        beat32(32'h00000000, 1'b1, 1'b1, 4'd7);
        expect32("keep_clamp", 32'h2144DF1C, 1'b1);

        // Back-to-back single-beat frames with result held off
        @(negedge clk);
        m_ready = 1'b0;
        beat32(32'h61626300, 1'b1, 1'b1, 4'd3);   // "abc"
        beat32(32'h61000000, 1'b1, 1'b1, 4'd1);   // "a"
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        chk("b2b_first_valid", {31'b0, m_valid}, 32'd1);
        chk("b2b_first_crc", m_crc, 32'h352441C2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_stall_ready", {31'b0, s_ready}, 32'd0);
            chk("b2b_hold_crc", m_crc, 32'h352441C2);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("b2b_second_valid", {31'b0, m_valid}, 32'd1);
        chk("b2b_second_crc", m_crc, 32'hE8B7BE43);
        chk("b2b_ready_back", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_drained", {31'b0, m_valid}, 32'd0);

        // Stray beat in IDLE: dropped, sticky error
        beat32(32'h31323334, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        s_valid = 1'b0;
        chk("stray_sop_err", {31'b0, sop_err}, 32'd1);
        chk("stray_no_result", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        chk("stray_no_result2", {31'b0, m_valid}, 32'd0);

        // Reset mid-frame with a result pending
        m_ready = 1'b0;
        beat32(32'h00000000, 1'b1, 1'b1, 4'd0);
        beat32(32'h31323334, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0;
        chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, m_valid}, 32'd0);
        chk("async_rst_crc", m_crc, 32'h0);
        chk("async_rst_ready", {31'b0, s_ready}, 32'd1);
        chk("async_rst_sop_err", {31'b0, sop_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_result", {31'b0, m_valid}, 32'd0);
        beat32(32'h31323334, 1'b1, 1'b0, 4'd0);
        beat32(32'h35363738, 1'b0, 1'b0, 4'd0);
        beat32(32'h39000000, 1'b0, 1'b1, 4'd1);
        expect32("post_rst_frame", 32'hCBF43926, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
